// File: rtl/cnt_sched_pkg.sv
// Shared state type, limits and helpers for the counter scheduler.
// Arbitration mode is chosen with the CNT_SCHED_RR_EN macro (see counter_scheduler).
package cnt_sched_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned CW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_sched_state_t;

    // Width of a requester index; never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_sched_arbiter.sv
// Combinational request arbiter: one-hot winner plus its index.
// CNT_SCHED_RR_EN selects round-robin from i_ptr; otherwise lowest index wins.
module cnt_sched_arbiter
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [PW-1:0]   o_idx
);

    logic w_found;

`ifdef CNT_SCHED_RR_EN
    logic [PW-1:0] w_cand;

    // Walk upward from the pointer, wrapping at NREQ; first asserted request wins.
    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = PW'((32'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                o_win[w_cand] = 1'b1;
                o_idx         = w_cand;
                w_found       = 1'b1;
            end
        end
    end
`else
    // Pointer has no meaning under fixed priority.
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[k]) begin
                o_win[k] = 1'b1;
                o_idx    = PW'(k);
                w_found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one internal up-counter among NREQ requesters, one interval per grant.
// Define CNT_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module counter_scheduler
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      count
);

    localparam int unsigned PW = ptr_width(NREQ);

    cnt_sched_state_t r_state;
    cnt_sched_state_t w_state_nxt;
    logic [CW-1:0]    r_target;
    logic [CW-1:0]    w_target_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [NREQ-1:0]  r_done;
    logic [NREQ-1:0]  w_done_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    w_owner_nxt;

    logic [NREQ-1:0]  w_win;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_ptr;
    logic [CW-1:0]    w_len_sel;

    cnt_sched_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_win (w_win),
        .o_idx (w_idx)
    );

    assign w_len_sel = len[32'(w_idx)*CW +: CW];

`ifdef CNT_SCHED_RR_EN
    logic [PW-1:0] r_ptr;

    // Pointer advances past the winner on every grant only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && (|req)) begin
            r_ptr <= (32'(w_idx) == NREQ - 1) ? '0 : w_idx + PW'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_count  <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_count  <= w_count_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    // Next-state and registered-output values; abort is tested before completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_count_nxt  = r_count;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_busy_nxt   = r_busy;
        w_owner_nxt  = r_owner;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt  = RUN;
                    w_target_nxt = w_len_sel;
                    w_count_nxt  = '0;
                    w_gnt_nxt    = w_win;
                    w_owner_nxt  = w_idx;
                    w_busy_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (!req[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_count_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_count == r_target) begin
                    w_state_nxt = DONE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed plus randomized bench for counter_scheduler against a timeline model.
module tb_counter_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 4;
`ifdef CNT_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int n_checks;
    int n_pass;
    int n_fail;

    // Model: a grant is a (owner, start edge, target) triple; outputs follow from elapsed edges.
    int n_edge;
    int m_owner;
    int m_start;
    int m_target;
    int m_count;
    int m_ptr;

    counter_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        int base;
        base = RR ? p : 0;
        for (int k = 0; k < 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge();
        int e;
        int w;
        n_edge++;
        if (m_owner >= 0) begin
            e = n_edge - m_start;
            if (e <= m_target + 1 && !req[m_owner]) begin
                m_owner = -1;
                m_count = 0;
            end else if (e >= m_target + 2) begin
                m_count = m_target;
                m_owner = -1;
            end
        end else if (req != 4'b0) begin
            w        = pick(req, m_ptr);
            m_owner  = w;
            m_start  = n_edge;
            m_target = int'(len[w*4 +: 4]);
            m_ptr    = (w + 1) % 4;
        end
    endtask

    task automatic check_model(input string tag);
        int         e;
        logic [3:0] eg;
        logic [3:0] ed;
        logic       eb;
        int         ec;
        eg = 4'b0;
        ed = 4'b0;
        eb = 1'b0;
        ec = m_count;
        if (m_owner >= 0) begin
            e  = n_edge - m_start;
            eb = 1'b1;
            if (e <= m_target) begin
                eg = 4'(1 << m_owner);
                ec = e;
            end else begin
                ed = 4'(1 << m_owner);
                ec = m_target;
            end
        end
        chk($sformatf("%s_gnt", tag),   32'(gnt),   32'(eg));
        chk($sformatf("%s_done", tag),  32'(done),  32'(ed));
        chk($sformatf("%s_busy", tag),  32'(busy),  32'(eb));
        chk($sformatf("%s_count", tag), 32'(count), 32'(ec));
    endtask

    task automatic cyc(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #1 reset_n = 1'b0;
        #1;
        chk($sformatf("%s_gnt", tag),   32'(gnt),   32'd0);
        chk($sformatf("%s_done", tag),  32'(done),  32'd0);
        chk($sformatf("%s_busy", tag),  32'(busy),  32'd0);
        chk($sformatf("%s_count", tag), 32'(count), 32'd0);
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int g;
        int d;
        int seq[$];
        logic [3:0] prev_g;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        n_edge   = 0;
        m_start  = 0;
        m_target = 0;
        model_reset();
        reset_n = 1'b0;
        req     = 4'b0;
        len     = 16'h0;

        #12;
        check_model("reset");
        reset_n = 1'b1;

        // Single interval of length 3
        req = 4'b0001;
        len = 16'h0003;
        g = 0;
        d = 0;
        for (int i = 0; i < 7; i++) begin
            cyc("t2");
            if (gnt == 4'b0001) g++;
            if (done == 4'b0001) d++;
            if (i == 4) req = 4'b0;
        end
        chk("t2_gnt_cycles", 32'(g), 32'd4);
        chk("t2_done_cycles", 32'(d), 32'd1);

        // Zero-length interval
        req = 4'b0001;
        len = 16'h0000;
        g = 0;
        d = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("t3");
            if (gnt == 4'b0001) g++;
            if (done == 4'b0001) d++;
            if (i == 1) req = 4'b0;
        end
        chk("t3_gnt_cycles", 32'(g), 32'd1);
        chk("t3_done_cycles", 32'(d), 32'd1);

        // Asynchronous reset in the middle of a run
        req = 4'b0001;
        len = 16'h0009;
        for (int i = 0; i < 6; i++) cyc("t1");
        chk("t1_pre_count", 32'(count), 32'd5);
        req = 4'b0;
        async_reset("t1_rst");

        // All requesting, all length 1, held
        req = 4'b1111;
        len = 16'h1111;
        prev_g = 4'b0;
        for (int i = 0; i < 20; i++) begin
            cyc("t4");
            if (gnt != 4'b0 && prev_g == 4'b0) begin
                for (int j = 0; j < 4; j++) if (gnt[j]) seq.push_back(j);
            end
            prev_g = gnt;
        end
        chk("t4_ngrants", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (seq.size() > i) chk($sformatf("t4_order%0d", i), 32'(seq[i]), RR ? 32'(i % 4) : 32'd0);
        end
        req = 4'b0;
        for (int i = 0; i < 3; i++) cyc("t4_idle");

        // Abort at count 4
        req = 4'b0100;
        len = 16'h0900;
        for (int i = 0; i < 5; i++) cyc("t5");
        chk("t5_pre_count", 32'(count), 32'd4);
        req = 4'b0;
        cyc("t5_abort");
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        cyc("t5_idle");

        // Second requester waits for done plus one idle cycle
        req = 4'b0001;
        len = 16'h0012;
        cyc("t6");
        req = 4'b0011;
        cyc("t6");
        cyc("t6");
        cyc("t6");
        chk("t6_done0", 32'(done), 32'd1);
        req = 4'b0010;
        cyc("t6");
        chk("t6_gap_gnt", 32'(gnt), 32'd0);
        chk("t6_gap_busy", 32'(busy), 32'd0);
        cyc("t6");
        chk("t6_gnt1", 32'(gnt), 32'd2);
        cyc("t6");
        cyc("t6");
        req = 4'b0;
        cyc("t6");
        cyc("t6");

        // Randomized traffic with aborts, length changes and one reset
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                end
            end
            if (m_owner >= 0 && n_edge - m_start == m_target + 1 && $urandom_range(1, 0) == 1)
                req[m_owner] = 1'b0;
            if ($urandom_range(7, 0) == 0) len = 16'($urandom);
            if (it == 250) async_reset("rnd_rst");
            cyc("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
